m68k_target: RTL and testbench

M68K_TARGET -- requirements
Module: m68k_target

---
 rtl/m68k_pkg.sv | 6 +
 rtl/m68k_target_if.sv | 20 ++
 rtl/m68k_sync2.sv | 15 +
 rtl/m68k_target.sv | 96 +++++++++
 tb/tb_m68k_target.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/m68k_pkg.sv
// m68k_pkg: shared FSM states and constants for the 68000 bus target.
package m68k_pkg;
   localparam int SYNC_DEPTH = 2;
   localparam logic [2:0] FC_INTACK = 3'b111;
   typedef enum logic [2:0] {IDLE, STROBE, ACCESS, WAITST, ACK, ABORT} m68k_state_e;
endpackage

// File: rtl/m68k_target_if.sv
// m68k_target_if: 68000 bus pins plus backend memory handshake seen by the target.
interface m68k_target_if #(parameter int WIN_BITS = 16);
   logic [23:1] M68K_A;
   logic [2:0] M68K_FC;
   logic M68K_AS_n, M68K_UDS_n, M68K_LDS_n, M68K_RW;
   logic [15:0] M68K_D_IN, M68K_D_OUT;
   logic M68K_D_OE, M68K_DTACK_n, M68K_BERR_n;
   logic MEM_REQ, MEM_WE, MEM_ACK;
   logic [WIN_BITS-2:0] MEM_ADDR;
   logic [1:0] MEM_BE;
   logic [15:0] MEM_WDATA, MEM_RDATA;
   modport slave (
      input M68K_A, M68K_FC, M68K_AS_n, M68K_UDS_n, M68K_LDS_n, M68K_RW, M68K_D_IN, MEM_RDATA, MEM_ACK,
      output M68K_D_OUT, M68K_D_OE, M68K_DTACK_n, M68K_BERR_n, MEM_REQ, MEM_WE, MEM_ADDR, MEM_BE, MEM_WDATA
   );
   modport master (
      output M68K_A, M68K_FC, M68K_AS_n, M68K_UDS_n, M68K_LDS_n, M68K_RW, M68K_D_IN, MEM_RDATA, MEM_ACK,
      input M68K_D_OUT, M68K_D_OE, M68K_DTACK_n, M68K_BERR_n, MEM_REQ, MEM_WE, MEM_ADDR, MEM_BE, MEM_WDATA
   );
endinterface

// File: rtl/m68k_sync2.sv
// m68k_sync2: strobe synchronizer, resets to the inactive (high) level.
module m68k_sync2
   import m68k_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);
   logic [SYNC_DEPTH-1:0] r;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r <= '1;
      else r <= {r[SYNC_DEPTH-2:0], d};
   assign q = r[SYNC_DEPTH-1];
endmodule

// File: rtl/m68k_target.sv
// m68k_target: 68000 bus slave bridging a fixed address window to a req/ack backend.
// Define M68K_TARGET_BERR_EN to add the backend timeout that raises BERR.
module m68k_target
   import m68k_pkg::*;
#(
   parameter logic [23:0] BASE_ADDR = 24'h200000,
   parameter int WIN_BITS = 16,
   parameter int WAIT_STATES = 0,
   parameter int BERR_CLKS = 64
) (
   input logic M68K_CLK,
   input logic M68K_RESET_n,
   m68k_target_if.slave bus
);
   logic as_s, uds_s, lds_s, hit, we_q, timeout, berr;
   logic [3:0] wcnt;
   logic [WIN_BITS-2:0] addr_q;
   logic [1:0] be_q;
   logic [15:0] wdata_q, rdata_q;
   m68k_state_e state, nxt;

   m68k_sync2 u_as (.clk(M68K_CLK), .rst_n(M68K_RESET_n), .d(bus.M68K_AS_n), .q(as_s));
   m68k_sync2 u_uds (.clk(M68K_CLK), .rst_n(M68K_RESET_n), .d(bus.M68K_UDS_n), .q(uds_s));
   m68k_sync2 u_lds (.clk(M68K_CLK), .rst_n(M68K_RESET_n), .d(bus.M68K_LDS_n), .q(lds_s));

   assign hit = !as_s && bus.M68K_A[23:WIN_BITS] == BASE_ADDR[23:WIN_BITS] && bus.M68K_FC != FC_INTACK;

   always_ff @(posedge M68K_CLK or negedge M68K_RESET_n)
      if (!M68K_RESET_n) state <= IDLE;
      else state <= nxt;

   // An ack coinciding with the strobe dropping completes nothing and needs no abort.
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    nxt = hit ? STROBE : IDLE;
         STROBE:  nxt = as_s ? IDLE : (!uds_s || !lds_s) ? ACCESS : STROBE;
         ACCESS:  nxt = (as_s && bus.MEM_ACK) ? IDLE : as_s ? ABORT :
                        bus.MEM_ACK ? (WAIT_STATES > 0 ? WAITST : ACK) : timeout ? ACK : ACCESS;
         WAITST:  nxt = wcnt == 4'd0 ? ACK : WAITST;
         ACK:     nxt = as_s ? IDLE : ACK;
         ABORT:   nxt = (bus.MEM_ACK || timeout) ? IDLE : ABORT;
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge M68K_CLK or negedge M68K_RESET_n)
      if (!M68K_RESET_n) begin
         addr_q <= '0;
         we_q <= 1'b0;
         be_q <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         wcnt <= '0;
      end else begin
         if (state == IDLE && hit) begin
            addr_q <= bus.M68K_A[WIN_BITS-1:1];
            we_q <= !bus.M68K_RW;
         end
         if (state == STROBE && nxt == ACCESS) begin
            be_q <= ~{uds_s, lds_s};
            if (we_q) wdata_q <= bus.M68K_D_IN;
         end
         if (state == ACCESS && bus.MEM_ACK && !as_s && !we_q) rdata_q <= bus.MEM_RDATA;
         wcnt <= (state == ACCESS && bus.MEM_ACK) ? 4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0) :
                 (state == WAITST && wcnt != 4'd0) ? wcnt - 4'd1 : wcnt;
      end

`ifdef M68K_TARGET_BERR_EN
   logic [15:0] tcnt;
   logic berr_q;
   always_ff @(posedge M68K_CLK or negedge M68K_RESET_n)
      if (!M68K_RESET_n) begin
         tcnt <= '0;
         berr_q <= 1'b0;
      end else begin
         tcnt <= (state == ACCESS || state == ABORT) ? tcnt + 16'd1 : '0;
         berr_q <= (state == ACCESS && nxt == ACK && !bus.MEM_ACK) ? 1'b1 : (state == IDLE) ? 1'b0 : berr_q;
      end
   assign timeout = tcnt == 16'(BERR_CLKS - 1);
   assign berr = berr_q;
`else
   assign timeout = 1'b0;
   assign berr = 1'b0;
`endif

   assign bus.MEM_REQ = state == ACCESS || state == ABORT;
   assign bus.MEM_WE = we_q;
   assign bus.MEM_ADDR = addr_q;
   assign bus.MEM_BE = be_q;
   assign bus.MEM_WDATA = wdata_q;
   assign bus.M68K_D_OUT = rdata_q;
   assign bus.M68K_D_OE = state == ACK && !we_q && !berr;
   assign bus.M68K_DTACK_n = !(state == ACK && !berr);
   assign bus.M68K_BERR_n = !(state == ACK && berr);
endmodule

// File: tb/tb_m68k_target.sv
// tb_m68k_target: directed bus cycles against a zero-wait and a three-wait target.
module tb_m68k_target;
   logic clk = 1'b0, rst_n = 1'b0;
   logic [23:1] a = '0;
   logic [2:0] fc = '0;
   logic as_n = 1'b1, uds_n = 1'b1, lds_n = 1'b1, rw = 1'b1, ack = 1'b0;
   logic [15:0] d_in = '0, rdata = '0;
   int total = 0, bad = 0;

   typedef struct packed {
      logic [14:0] addr;
      logic [1:0] be;
      logic we;
      logic [15:0] wdata;
      logic [15:0] rdata;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   m68k_target_if b0 ();
   m68k_target_if b3 ();
   assign b0.M68K_A = a;       assign b3.M68K_A = a;
   assign b0.M68K_FC = fc;     assign b3.M68K_FC = fc;
   assign b0.M68K_AS_n = as_n; assign b3.M68K_AS_n = as_n;
   assign b0.M68K_UDS_n = uds_n; assign b3.M68K_UDS_n = uds_n;
   assign b0.M68K_LDS_n = lds_n; assign b3.M68K_LDS_n = lds_n;
   assign b0.M68K_RW = rw;     assign b3.M68K_RW = rw;
   assign b0.M68K_D_IN = d_in; assign b3.M68K_D_IN = d_in;
   assign b0.MEM_RDATA = rdata; assign b3.MEM_RDATA = rdata;
   assign b0.MEM_ACK = ack;    assign b3.MEM_ACK = ack;

   m68k_target #(.WAIT_STATES(0)) dut0 (.M68K_CLK(clk), .M68K_RESET_n(rst_n), .bus(b0));
   m68k_target #(.WAIT_STATES(3)) dut3 (.M68K_CLK(clk), .M68K_RESET_n(rst_n), .bus(b3));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic end_cycle();
      as_n = 1'b1;
      uds_n = 1'b1;
      lds_n = 1'b1;
   endtask

   task automatic start_cycle(input logic [23:0] ad, input logic [2:0] f, input logic r,
                              input logic [1:0] be, input logic [15:0] din, input logic [15:0] rd);
      a = ad[23:1];
      fc = f;
      rw = r;
      rdata = rd;
      as_n = 1'b0;
      sb.push_back(exp_t'{ad[15:1], be, !r, din, rd});
      tick();
      uds_n = ~be[1];
      lds_n = ~be[0];
      d_in = din;
   endtask

   task automatic wait_req(output exp_t e);
      int n = 0;
      while (b0.MEM_REQ !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      chk("req_seen", 32'(b0.MEM_REQ), 1);
      e = sb.pop_front();
      chk("mem_addr", 32'(b0.MEM_ADDR), 32'(e.addr));
      chk("mem_addr_ws3", 32'(b3.MEM_ADDR), 32'(e.addr));
      chk("mem_be", 32'(b0.MEM_BE), 32'(e.be));
      chk("mem_we", 32'(b0.MEM_WE), 32'(e.we));
      if (e.we) chk("mem_wdata", 32'(b0.MEM_WDATA), 32'(e.wdata));
   endtask

   task automatic bus_cycle(input logic [23:0] ad, input logic [2:0] f, input logic r,
                            input logic [1:0] be, input logic [15:0] din, input logic [15:0] rd);
      exp_t e;
      start_cycle(ad, f, r, be, din, rd);
      wait_req(e);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      chk("dtack_lat", 32'(b0.M68K_DTACK_n), 0);
      chk("d_oe", 32'(b0.M68K_D_OE), e.we ? 0 : 1);
      if (!e.we) chk("d_out", 32'(b0.M68K_D_OUT), 32'(e.rdata));
      tick();
      tick();
      chk("dtack_ws3_early", 32'(b3.M68K_DTACK_n), 1);
      tick();
      chk("dtack_ws3", 32'(b3.M68K_DTACK_n), 0);
      end_cycle();
      tick();
      tick();
      chk("dtack_hold", 32'(b0.M68K_DTACK_n), 0);
      tick();
      chk("dtack_rel", 32'(b0.M68K_DTACK_n), 1);
      chk("d_oe_rel", 32'(b0.M68K_D_OE), 0);
      tick();
   endtask

   task automatic miss(input logic [23:0] ad, input logic [2:0] f);
      int seen = 0;
      a = ad[23:1];
      fc = f;
      rw = 1'b1;
      as_n = 1'b0;
      uds_n = 1'b0;
      lds_n = 1'b0;
      repeat (10) begin
         tick();
         if (b0.MEM_REQ || !b0.M68K_DTACK_n) seen++;
      end
      chk("miss", 32'(seen), 0);
      end_cycle();
      repeat (3) tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      int dt;
      tick();
      chk("rst_dtack", 32'(b0.M68K_DTACK_n), 1);
      chk("rst_berr", 32'(b0.M68K_BERR_n), 1);
      chk("rst_req", 32'(b0.MEM_REQ), 0);
      chk("rst_doe", 32'(b0.M68K_D_OE), 0);
      rst_n = 1'b1;
      repeat (2) tick();

      bus_cycle(24'h200010, 3'b101, 1'b1, 2'b11, 16'h0000, 16'hBEEF);
      bus_cycle(24'h200003, 3'b101, 1'b0, 2'b01, 16'h0055, 16'h0000);
      bus_cycle(24'h20FFFE, 3'b110, 1'b1, 2'b10, 16'h0000, 16'h5AA5);
      miss(24'h300000, 3'b101);
      miss(24'h200010, 3'b111);

      start_cycle(24'h200040, 3'b101, 1'b1, 2'b11, 16'h0000, 16'hDEAD);
      wait_req(e);
      end_cycle();
      dt = 0;
      repeat (5) begin
         tick();
         if (!b0.M68K_DTACK_n) dt++;
      end
      chk("abort_req_held", 32'(b0.MEM_REQ), 1);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      chk("abort_idle", 32'(b0.MEM_REQ), 0);
      chk("abort_no_dtack", 32'(dt) + 32'(!b0.M68K_DTACK_n), 0);
      repeat (2) tick();

      start_cycle(24'h200080, 3'b101, 1'b1, 2'b11, 16'h0000, 16'h0000);
      wait_req(e);
`ifdef M68K_TARGET_BERR_EN
      repeat (63) tick();
      chk("berr_early", 32'(b0.M68K_BERR_n), 1);
      tick();
      chk("berr", 32'(b0.M68K_BERR_n), 0);
      chk("berr_req_drop", 32'(b0.MEM_REQ), 0);
      chk("berr_no_dtack", 32'(b0.M68K_DTACK_n), 1);
      end_cycle();
      repeat (3) tick();
      chk("berr_rel", 32'(b0.M68K_BERR_n), 1);
`else
      repeat (100) tick();
      chk("hang_req", 32'(b0.MEM_REQ), 1);
      chk("hang_dtack", 32'(b0.M68K_DTACK_n), 1);
      chk("hang_berr", 32'(b0.M68K_BERR_n), 1);
      end_cycle();
      repeat (3) tick();
      ack = 1'b1;
      tick();
      ack = 1'b0;
      chk("hang_idle", 32'(b0.MEM_REQ), 0);
`endif
      repeat (2) tick();

      start_cycle(24'h2000A4, 3'b101, 1'b0, 2'b10, 16'hA500, 16'h0000);
      wait_req(e);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      chk("pre_rst_we", 32'(b3.MEM_WE), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_req", 32'(b3.MEM_REQ), 0);
      chk("arst_we", 32'(b3.MEM_WE), 0);
      chk("arst_be", 32'(b3.MEM_BE), 0);
      chk("arst_addr", 32'(b3.MEM_ADDR), 0);
      chk("arst_wdata", 32'(b3.MEM_WDATA), 0);
      chk("arst_dout", 32'(b3.M68K_D_OUT), 0);
      chk("arst_doe", 32'(b3.M68K_D_OE), 0);
      chk("arst_dtack", 32'(b3.M68K_DTACK_n), 1);
      chk("arst_berr", 32'(b3.M68K_BERR_n), 1);
      chk("arst_dtack0", 32'(b0.M68K_DTACK_n), 1);
      end_cycle();
      tick();
      rst_n = 1'b1;
      repeat (3) tick();
      bus_cycle(24'h200020, 3'b101, 1'b1, 2'b11, 16'h0000, 16'h1234);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
